// File: rtl/harness_pkg.sv
// Shared definitions for the host-side test-harness blocks.
package harness_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CAPTURE = 3'd1,
    ST_SHIFT   = 3'd2,
    ST_UPDATE  = 3'd3,
    ST_HOLD    = 3'd4
  } harness_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Bits needed to hold the values 0..n inclusive.
  function automatic int cnt_bits(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/harness_shift_counter.sv
// Loadable up-counter with a terminal-count flag; paces the shift phase.
module harness_shift_counter #(
  parameter int CNT_WIDTH = 4,
  parameter int TERM      = 7
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 load,
  input  logic [CNT_WIDTH-1:0] load_val,
  input  logic                 inc,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 tc
);

  localparam logic [CNT_WIDTH-1:0] TERM_V = CNT_WIDTH'(TERM);

  // Load has priority over increment.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)  count <= '0;
    else if (load) count <= load_val;
    else if (inc)  count <= count + CNT_WIDTH'(1);
  end

  assign tc = (count == TERM_V);

endmodule

// File: rtl/harness_serial_driver.sv
// Host end of the harness serial chain: shifts a stimulus word out MSB-first
// while shifting the DUT result in, and strobes capture/update around it.
module harness_serial_driver
  import harness_pkg::*;
#(
  parameter int IN_WIDTH  = 60,
  parameter int OUT_WIDTH = 60
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [IN_WIDTH-1:0]  tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic [OUT_WIDTH-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 capture,
  output logic                 shift_en,
  output logic                 update,
  output logic                 serial_out,
  input  logic                 serial_in
);

  localparam int LEN       = max_int(IN_WIDTH, OUT_WIDTH);
  localparam int CNT_WIDTH = cnt_bits(LEN);
  localparam logic [CNT_WIDTH-1:0] OUT_LIM = CNT_WIDTH'(OUT_WIDTH);

  if (LEN < 1) begin : g_len_chk
    $error("harness_serial_driver: LEN must be at least 1");
  end

  harness_state_e        state;
  logic [IN_WIDTH-1:0]   tx_shift;
  logic [CNT_WIDTH-1:0]  count;
  logic                  tc;
  logic                  accept;
  logic                  in_shift;

  assign accept   = tx_valid & tx_ready;
  assign in_shift = (state == ST_SHIFT);

  harness_shift_counter #(
    .CNT_WIDTH (CNT_WIDTH),
    .TERM      (LEN - 1)
  ) u_cnt (
    .clock    (clock),
    .reset_n  (reset_n),
    .load     (accept),
    .load_val ('0),
    .inc      (in_shift),
    .count    (count),
    .tc       (tc)
  );

  // Transaction FSM with all handshake/strobe outputs registered.
  // serial_out is loaded one edge ahead from tx_shift, so tx_shift runs one
  // bit ahead of the line; zero fill covers shift cycles past IN_WIDTH.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      tx_shift   <= '0;
      rx_data    <= '0;
      tx_ready   <= 1'b1;
      rx_valid   <= 1'b0;
      capture    <= 1'b0;
      shift_en   <= 1'b0;
      update     <= 1'b0;
      serial_out <= 1'b0;
    end else begin
      capture <= 1'b0;
      update  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            tx_shift <= tx_data;
            tx_ready <= 1'b0;
            capture  <= 1'b1;
            state    <= ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          shift_en   <= 1'b1;
          serial_out <= tx_shift[IN_WIDTH-1];
          tx_shift   <= tx_shift << 1;
          state      <= ST_SHIFT;
        end
        ST_SHIFT: begin
          // Only the first OUT_WIDTH samples are kept; first sample ends as MSB.
          if (count < OUT_LIM)
            rx_data <= (rx_data << 1) | OUT_WIDTH'(serial_in);
          if (tc) begin
            shift_en   <= 1'b0;
            serial_out <= 1'b0;
            update     <= 1'b1;
            state      <= ST_UPDATE;
          end else begin
            serial_out <= tx_shift[IN_WIDTH-1];
            tx_shift   <= tx_shift << 1;
          end
        end
        ST_UPDATE: begin
          rx_valid <= 1'b1;
          state    <= ST_HOLD;
        end
        ST_HOLD: begin
          if (rx_ready) begin
            rx_valid <= 1'b0;
            tx_ready <= 1'b1;
            state    <= ST_IDLE;
          end
        end
        default: begin
          state      <= ST_IDLE;
          tx_ready   <= 1'b1;
          rx_valid   <= 1'b0;
          shift_en   <= 1'b0;
          serial_out <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_harness_serial_driver.sv
// Scoreboard bench for harness_serial_driver, run in two width configurations.
module tb_harness_serial_driver;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  bit done [2];

  typedef struct {
    int a;
    int tx;
  } txn_t;

  task automatic chk(input int cfg, input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL cfg%0d %s: got %0h expected %0h at %0t", cfg, name, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_cfg
    localparam int IW     = (g == 0) ? 8 : 4;
    localparam int OW     = (g == 0) ? 4 : 8;
    localparam int LEN    = (IW > OW) ? IW : OW;
    localparam int DIR_TX = (g == 0) ? 'hA5 : 'h9;
    localparam int DIR_SI = (g == 0) ? 'hB : 'hCA;
    localparam int DIR_SO = (g == 0) ? 'hA5 : 'h90;
    localparam int NRAND  = (g == 0) ? 20 : 6;
    localparam int HSZ    = 4096;

    logic          reset_n;
    logic [IW-1:0] tx_data;
    logic          tx_valid, tx_ready;
    logic [OW-1:0] rx_data;
    logic          rx_valid, rx_ready;
    logic          capture, shift_en, update, serial_out, serial_in;

    harness_serial_driver #(.IN_WIDTH(IW), .OUT_WIDTH(OW)) dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .tx_data    (tx_data),
      .tx_valid   (tx_valid),
      .tx_ready   (tx_ready),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .rx_ready   (rx_ready),
      .capture    (capture),
      .shift_en   (shift_en),
      .update     (update),
      .serial_out (serial_out),
      .serial_in  (serial_in)
    );

    // Reference model: per-cycle expected strobes and line bits, filled in
    // when a word is accepted; results come from recorded serial_in history.
    txn_t sb[$];
    bit   exp_cap [HSZ];
    bit   exp_sh  [HSZ];
    bit   exp_up  [HSZ];
    bit   exp_so  [HSZ];
    bit   si_hist [HSZ];
    int   cyc = 0;
    bit   mon_en = 0;
    bit   si_rand = 0;

    always @(posedge clock) cyc <= cyc + 1;

    initial forever begin : monitor
      bit ev, rdy_m;
      int er, tv;
      @(negedge clock);
      if (mon_en && cyc < HSZ - 64) begin
        si_hist[cyc] = serial_in;
        if (!reset_n) begin
          sb.delete();
          for (int i = cyc; i < HSZ; i++) begin
            exp_cap[i] = 0; exp_sh[i] = 0; exp_up[i] = 0; exp_so[i] = 0;
          end
        end
        rdy_m = (sb.size() == 0);
        ev    = !rdy_m && (cyc >= sb[0].a + LEN + 3);
        chk(g, "tx_ready",   tx_ready,   rdy_m);
        chk(g, "rx_valid",   rx_valid,   ev);
        chk(g, "capture",    capture,    exp_cap[cyc]);
        chk(g, "shift_en",   shift_en,   exp_sh[cyc]);
        chk(g, "update",     update,     exp_up[cyc]);
        chk(g, "serial_out", serial_out, exp_so[cyc]);
        if (ev) begin
          er = 0;
          for (int k = 0; k < OW; k++) er = (er << 1) | int'(si_hist[sb[0].a + 2 + k]);
          chk(g, "rx_data", rx_data, er);
          if (rx_ready) void'(sb.pop_front());
        end
        if (reset_n && rdy_m && tx_valid) begin
          tv = int'(tx_data);
          sb.push_back('{cyc, tv});
          exp_cap[cyc + 1] = 1;
          for (int k = 0; k < LEN; k++) begin
            exp_sh[cyc + 2 + k] = 1;
            exp_so[cyc + 2 + k] = (k < IW) ? bit'((tv >> (IW - 1 - k)) & 1) : 1'b0;
          end
          exp_up[cyc + LEN + 2] = 1;
        end
      end
    end

    task automatic tick();
      @(posedge clock);
      #1;
      if (si_rand) serial_in = 1'($urandom);
    endtask

    // Returns one tick after the accepting edge, i.e. in the capture cycle.
    task automatic wait_accept(input string what);
      int n = 0;
      while (!(tx_ready && tx_valid) && n < 100) begin tick(); n++; end
      if (n >= 100) begin
        checks++; errors++;
        $display("FAIL cfg%0d %s: no accept within 100 cycles", g, what);
      end
      tick();
    endtask

    task automatic wait_rx();
      int n = 0;
      while (!rx_valid && n < 100) begin tick(); n++; end
      if (n >= 100) begin
        checks++; errors++;
        $display("FAIL cfg%0d rx wait: rx_valid absent after 100 cycles", g);
      end
    endtask

    initial begin : stim
      logic [OW-1:0] si_pat;
      int so_seq;
      reset_n = 1; tx_valid = 0; tx_data = '0; rx_ready = 0; serial_in = 0;
      #3 reset_n = 0; mon_en = 1;
      #1;
      chk(g, "rst tx_ready", tx_ready, 1);
      chk(g, "rst rx_valid", rx_valid, 0);
      chk(g, "rst serial_out", serial_out, 0);
      chk(g, "rst strobes", {capture, update, shift_en}, 0);
      repeat (3) tick();
      reset_n = 1;
      tick();

      // Directed word with a fixed serial_in pattern.
      si_pat   = OW'(DIR_SI);
      tx_data  = IW'(DIR_TX);
      tx_valid = 1;
      wait_accept("dir accept");
      tx_valid = 0;
      chk(g, "dir capture", capture, 1);
      so_seq = 0;
      for (int k = 0; k < LEN; k++) begin
        tick();
        serial_in = (k < OW) ? si_pat[OW - 1 - k] : 1'b0;
        chk(g, "dir shift_en", shift_en, 1);
        so_seq = (so_seq << 1) | int'(serial_out);
      end
      chk(g, "dir serial_out seq", so_seq, DIR_SO);
      tick();
      chk(g, "dir update", update, 1);
      tick();
      chk(g, "dir rx_valid", rx_valid, 1);
      chk(g, "dir rx_data", rx_data, DIR_SI);

      // Stall in HOLD with a competing stimulus word.
      tx_valid = 1; tx_data = ~tx_data;
      for (int k = 0; k < 5; k++) begin
        tick();
        chk(g, "hold rx_valid", rx_valid, 1);
        chk(g, "hold rx_data", rx_data, DIR_SI);
        chk(g, "hold tx_ready", tx_ready, 0);
      end
      tx_valid = 0; rx_ready = 1;
      tick();
      rx_ready = 0;
      chk(g, "post hs rx_valid", rx_valid, 0);
      chk(g, "post hs tx_ready", tx_ready, 1);

      // Random single transfers with random consumer delay.
      si_rand = 1;
      for (int t = 0; t < 3; t++) begin
        tx_data = IW'($urandom); tx_valid = 1;
        wait_accept("single accept");
        tx_valid = 0;
        wait_rx();
        repeat ($urandom_range(0, 3)) tick();
        rx_ready = 1;
        tick();
        rx_ready = 0;
      end

      // Back-to-back streaming with both sides always ready.
      rx_ready = 1; tx_valid = 1;
      for (int t = 0; t < NRAND; t++) begin
        tx_data = IW'($urandom);
        wait_accept("b2b accept");
      end
      tx_valid = 0;
      repeat (LEN + 6) tick();
      rx_ready = 0;

      // Reset pulse in shift cycle 3, then a clean transaction.
      tx_data = IW'($urandom); tx_valid = 1;
      wait_accept("abort accept");
      tx_valid = 0;
      repeat (4) tick();
      #2 reset_n = 0;
      #1;
      chk(g, "abort tx_ready", tx_ready, 1);
      chk(g, "abort rx_valid", rx_valid, 0);
      chk(g, "abort shift_en", shift_en, 0);
      chk(g, "abort serial_out", serial_out, 0);
      repeat (2) tick();
      reset_n = 1;
      tick();
      rx_ready = 1; tx_data = IW'($urandom); tx_valid = 1;
      wait_accept("recover accept");
      tx_valid = 0;
      repeat (LEN + 6) tick();
      done[g] = 1;
    end
  end

  initial begin
    fork
      wait (done[0] && done[1]);
      begin
        #400000;
        errors++;
        $display("FAIL timeout: bench did not complete");
      end
    join_any
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/harness_serial_driver.md
Name: harness_serial_driver

Overview:
- Host-side endpoint of the test-harness serial chain: drives the bit-serial input of a harness input register and collects the bit-serial output of a harness output register.
- Accepts one parallel stimulus word per transaction over a valid/ready handshake and shifts it out MSB-first.
- Simultaneously shifts in the DUT result, presents it as a parallel word over a valid/ready handshake, and generates the capture/update strobes the harness registers need.
- Sits in the bench/FPGA top level, opposite the DUT-side harness wrapper.

Parameters:
- IN_WIDTH, 60, bits shifted out per transaction (width of the DUT-side input register).
- OUT_WIDTH, 60, bits shifted in per transaction (width of the DUT-side output register).
- LEN (localparam), max(IN_WIDTH, OUT_WIDTH), shift cycles per transaction.
- CNT_WIDTH (localparam), clog2(LEN+1), shift counter width.

Ports:
- clock  input  1  single clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- tx_data  input  IN_WIDTH  stimulus word.
- tx_valid  input  1  stimulus word present.
- tx_ready  output  1  driver can accept a stimulus word.
- rx_data  output  OUT_WIDTH  captured result word.
- rx_valid  output  1  rx_data holds a complete result.
- rx_ready  input  1  consumer accepts rx_data.
- capture  output  1  one-cycle pulse: DUT-side output register parallel-loads.
- shift_en  output  1  high during every shift cycle (rden/wren of the harness registers).
- update  output  1  one-cycle pulse: DUT-side input register contents are complete.
- serial_out  output  1  to harness test_in.
- serial_in  input  1  from harness test_out.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - State goes to IDLE.
  - tx_shift, rx_data and the counter go to 0.
  - tx_ready=1 (IDLE), rx_valid=0, capture=0, shift_en=0, update=0, serial_out=0.
- FSM states: IDLE, CAPTURE, SHIFT, UPDATE, HOLD.
- IDLE: tx_ready=1.
  - On tx_valid & tx_ready: tx_shift <= tx_data, counter <= 0, go to CAPTURE.
  - tx_valid while not in IDLE is ignored; tx_data must then be held by the source.
- CAPTURE: exactly 1 cycle, capture=1, then SHIFT.
- SHIFT: exactly LEN cycles, shift_en=1.
  - serial_out = tx_shift[IN_WIDTH-1] (register output, no combinational path from inputs).
  - Each cycle, tx_shift shifts left with zero fill, so cycles IN_WIDTH..LEN-1 drive 0.
  - Each cycle with counter < OUT_WIDTH, rx_data <= {rx_data[OUT_WIDTH-2:0], serial_in}. The first sampled bit therefore ends up as the MSB.
  - The counter increments each cycle; when counter == LEN-1, go to UPDATE.
- UPDATE: exactly 1 cycle, update=1, shift_en=0, then HOLD.
- HOLD: rx_valid=1, rx_data stable.
  - On rx_ready, go to IDLE; rx_valid drops on the next cycle.
  - rx_ready asserted outside HOLD has no effect.
- Latency:
  - Accept to capture pulse: 1 cycle.
  - Accept to rx_valid: LEN+3 cycles.
  - Minimum transaction period: LEN+4 cycles (rx_ready already high in HOLD).
- Mid-transaction reset: state aborts immediately to the reset values; the partial rx_data is discarded and rx_valid is not asserted.
- OUT_WIDTH==1 and IN_WIDTH==1 are legal. LEN ≥ 1 is enforced with an elaboration-time error.
- serial_out is 0 in every state except SHIFT.

Decomposition:
- Shared package `harness_pkg`: the state enum (IDLE, CAPTURE, SHIFT, UPDATE, HOLD) and a max()/clog2 helper, reused by other harness blocks.
- One natural sub-module, `harness_shift_counter`: loadable up-counter with a terminal-count flag, parameterised by CNT_WIDTH and terminal value LEN-1.
- The shift registers stay inline.

Test Plan (IN_WIDTH=8, OUT_WIDTH=4, LEN=8 unless noted):
1. Reset held, then released -> tx_ready=1, rx_valid=0, serial_out=0, capture/update/shift_en=0.
2. Send tx_data=8'hA5 while serial_in is driven with 1,0,1,1 over the first four shift cycles, then 0 -> capture pulse 1 cycle after accept; serial_out=1,0,1,0,0,1,0,1 over 8 shift_en cycles; update pulse; rx_data=4'hB, rx_valid on cycle 11 after accept.
3. Hold rx_ready=0 for 5 cycles in HOLD -> rx_valid and rx_data stay stable; tx_ready=0 throughout; a tx_valid during that time is not accepted.
4. Back-to-back transfers with tx_valid and rx_ready held high -> new accept every 12 cycles, no dropped or duplicated words across 20 random words (scoreboard against a model).
5. IN_WIDTH=4, OUT_WIDTH=8, tx_data=4'h9 -> serial_out=1,0,0,1,0,0,0,0; all 8 serial_in samples land in rx_data.
6. reset_n pulsed low in shift cycle 3 -> outputs return to reset values asynchronously; rx_valid never asserts; the next transaction completes correctly.
